// File: rtl/muldiv_pkg.sv
// Shared definitions for the iterative multiply/divide unit.
// Contents:
//   - operation codes carried on i_op
//   - FSM state encoding
//   - clogb2(): bits needed to hold values 0 .. value-1 (sizes the bit counter)
package muldiv_pkg;

  localparam int OP_MULT  = 0;
  localparam int OP_MULTU = 1;
  localparam int OP_DIV   = 2;
  localparam int OP_DIVU  = 3;
  localparam int OP_MTHI  = 4;
  localparam int OP_MTLO  = 5;

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_RUN  = 2'b01,
    ST_FIX  = 2'b10
  } state_e;

  // Ceiling log2, never less than 1, so a counter of this width can hold value-1.
  function automatic int clogb2(input int value);
    int res;
    res = 0;
    for (int v = value - 1; v > 0; v = v >> 1) begin
      res++;
    end
    if (res == 0) begin
      res = 1;
    end
    return res;
  endfunction

endpackage

// File: rtl/muldiv_step.sv
// Single iteration of the multiply/divide datapath (purely combinational).
// Ports:
//   acc      in  2*NB_DATA  current accumulator
//                           multiply: {partial sum, product bits shifted in}
//                           divide:   {partial remainder, quotient bits}
//   addend   in  NB_DATA    multiplicand magnitude (mul) / divisor magnitude (div)
//   data_bit in  1          next multiplier bit (LSB first) / next dividend bit (MSB first)
//   is_div   in  1          selects divide step instead of multiply step
//   acc_next out 2*NB_DATA  accumulator after this iteration
module muldiv_step
  import muldiv_pkg::*;
#(
  parameter int NB_DATA = 32
) (
  input  logic [2*NB_DATA-1:0] acc,
  input  logic [NB_DATA-1:0]   addend,
  input  logic                 data_bit,
  input  logic                 is_div,
  output logic [2*NB_DATA-1:0] acc_next
);

  logic [NB_DATA-1:0] addend_gated;
  logic [NB_DATA:0]   sum;
  logic [NB_DATA:0]   r_shift;
  logic [NB_DATA-1:0] diff;
  logic               ge;

  // NOTE: every always_comb output gets a value on every path (here by
  // straight-line assignment), otherwise synthesis infers a latch.
  always_comb begin
    // Multiply: add the multiplicand into the upper half when the current
    // multiplier bit is set, then shift the whole accumulator right by one.
    addend_gated = data_bit ? addend : {NB_DATA{1'b0}};
    sum          = {1'b0, acc[2*NB_DATA-1:NB_DATA]} + {1'b0, addend_gated};

    // Divide: bring the next dividend bit into the partial remainder and try
    // subtracting the divisor. The remainder stays below the divisor, so the
    // difference always fits NB_DATA bits when the trial succeeds.
    r_shift = {acc[2*NB_DATA-1:NB_DATA], data_bit};
    diff    = r_shift[NB_DATA-1:0] - addend;
    ge      = (r_shift >= {1'b0, addend});

    if (is_div) begin
      acc_next = {(ge ? diff : r_shift[NB_DATA-1:0]), acc[NB_DATA-2:0], ge};
    end else begin
      acc_next = {sum, acc[NB_DATA-1:1]};
    end
  end

endmodule

// File: rtl/muldiv_unit.sv
// Iterative multiply/divide unit with architectural HI/LO registers.
// MULT/MULTU/DIV/DIVU run one bit per cycle (RUN) followed by a sign-fix and
// write-back cycle (FIX); MTHI/MTLO write HI/LO directly from IDLE.
// Ports:
//   i_clock     in  1             clock, rising edge
//   i_reset     in  1             asynchronous active-low reset
//   i_valid     in  1             operation request, taken when o_ready
//   i_op        in  NB_OPERATION  MULT=0 MULTU=1 DIV=2 DIVU=3 MTHI=4 MTLO=5 (6,7 no-op)
//   i_data_a    in  NB_DATA       multiplicand / dividend / MTHI-MTLO source
//   i_data_b    in  NB_DATA       multiplier / divisor
//   i_flush     in  1             abort an operation in flight
//   o_ready     out 1             unit idle, can accept
//   o_busy      out 1             multiply/divide in flight
//   o_done      out 1             one-cycle pulse after HI/LO take a result
//   o_div_zero  out 1             pulse with o_done when the divisor was zero
//   o_hi, o_lo  out NB_DATA       HI and LO registers
module muldiv_unit
  import muldiv_pkg::*;
#(
  parameter int NB_DATA      = 32,
  parameter int NB_OPERATION = 3
) (
  input  logic                    i_clock,
  input  logic                    i_reset,
  input  logic                    i_valid,
  input  logic [NB_OPERATION-1:0] i_op,
  input  logic [NB_DATA-1:0]      i_data_a,
  input  logic [NB_DATA-1:0]      i_data_b,
  input  logic                    i_flush,
  output logic                    o_ready,
  output logic                    o_busy,
  output logic                    o_done,
  output logic                    o_div_zero,
  output logic [NB_DATA-1:0]      o_hi,
  output logic [NB_DATA-1:0]      o_lo
);

  localparam int NB_COUNT = clogb2(NB_DATA);

  state_e state, state_next;

  logic [NB_COUNT-1:0]  count;
  logic [2*NB_DATA-1:0] acc;
  logic [2*NB_DATA-1:0] acc_step;
  logic [NB_DATA-1:0]   addend;    // multiplicand (mul) or divisor (div) magnitude
  logic [NB_DATA-1:0]   shifter;   // multiplier (mul) or dividend (div) magnitude
  logic [NB_DATA-1:0]   a_raw;     // untouched dividend, returned on divide by zero
  logic                 is_div;
  logic                 sign_p;    // negate product / quotient
  logic                 sign_r;    // negate remainder
  logic                 div_zero;
  logic [NB_DATA-1:0]   hi, lo;
  logic                 done, div_zero_pulse;

  // Request decode
  logic               accept, start, op_signed, op_div;
  logic               a_neg, b_neg;
  logic [NB_DATA-1:0] mag_a, mag_b;

  // Write-back values formed in FIX
  logic               write_en;
  logic [NB_DATA-1:0] res_hi, res_lo;
  logic [2*NB_DATA-1:0] prod_signed;

  assign accept    = i_valid && (state == ST_IDLE);
  assign op_div    = (i_op == NB_OPERATION'(OP_DIV)) || (i_op == NB_OPERATION'(OP_DIVU));
  assign start     = accept && (op_div || (i_op == NB_OPERATION'(OP_MULT)) ||
                                (i_op == NB_OPERATION'(OP_MULTU)));
  assign op_signed = (i_op == NB_OPERATION'(OP_MULT)) || (i_op == NB_OPERATION'(OP_DIV));
  assign a_neg     = op_signed && i_data_a[NB_DATA-1];
  assign b_neg     = op_signed && i_data_b[NB_DATA-1];
  // The most negative value maps onto itself, which is the right unsigned
  // magnitude 2^(NB_DATA-1); MIN / -1 therefore needs no special case.
  assign mag_a     = a_neg ? -i_data_a : i_data_a;
  assign mag_b     = b_neg ? -i_data_b : i_data_b;

  // A flush landing on the FIX edge suppresses the write.
  assign write_en  = (state == ST_FIX) && !i_flush;

  muldiv_step #(
    .NB_DATA (NB_DATA)
  ) u_step (
    .acc      (acc),
    .addend   (addend),
    .data_bit (is_div ? shifter[NB_DATA-1] : shifter[0]),
    .is_div   (is_div),
    .acc_next (acc_step)
  );

  // ---------------------------------------------------------------- FSM
  // NOTE: state and all other registers use non-blocking assignments so every
  // flop samples the pre-edge values regardless of statement order.
  always_ff @(posedge i_clock or negedge i_reset) begin
    if (!i_reset) begin
      state <= ST_IDLE;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next = state;
    unique case (state)
      ST_IDLE: if (start)                state_next = ST_RUN;
      ST_RUN:  if (i_flush)              state_next = ST_IDLE;
               else if (count == '0)     state_next = ST_FIX;
      ST_FIX:                            state_next = ST_IDLE;
      default:                           state_next = ST_IDLE;
    endcase
  end

  assign o_ready = (state == ST_IDLE);
  assign o_busy  = (state == ST_RUN) || (state == ST_FIX);

  // ---------------------------------------------------------- sign fixup
  always_comb begin
    prod_signed = sign_p ? -acc : acc;
    res_hi      = prod_signed[2*NB_DATA-1:NB_DATA];
    res_lo      = prod_signed[NB_DATA-1:0];
    if (is_div) begin
      if (div_zero) begin
        res_hi = a_raw;
        res_lo = {NB_DATA{1'b1}};
      end else begin
        res_lo = sign_p ? -acc[NB_DATA-1:0] : acc[NB_DATA-1:0];
        res_hi = sign_r ? -acc[2*NB_DATA-1:NB_DATA] : acc[2*NB_DATA-1:NB_DATA];
      end
    end
  end

  // ------------------------------------------------------------ datapath
  // NOTE: operand/accumulator flops are reset along with HI/LO; they are few
  // and it keeps every register at a known value after reset.
  always_ff @(posedge i_clock or negedge i_reset) begin
    if (!i_reset) begin
      count          <= '0;
      acc            <= '0;
      addend         <= '0;
      shifter        <= '0;
      a_raw          <= '0;
      is_div         <= 1'b0;
      sign_p         <= 1'b0;
      sign_r         <= 1'b0;
      div_zero       <= 1'b0;
      hi             <= '0;
      lo             <= '0;
      done           <= 1'b0;
      div_zero_pulse <= 1'b0;
    end else begin
      done           <= write_en;
      div_zero_pulse <= write_en && is_div && div_zero;

      if (accept && (i_op == NB_OPERATION'(OP_MTHI))) begin
        hi <= i_data_a;
      end
      if (accept && (i_op == NB_OPERATION'(OP_MTLO))) begin
        lo <= i_data_a;
      end

      if (start) begin
        is_div   <= op_div;
        addend   <= op_div ? mag_b : mag_a;
        shifter  <= op_div ? mag_a : mag_b;
        a_raw    <= i_data_a;
        sign_p   <= a_neg ^ b_neg;
        sign_r   <= a_neg;
        div_zero <= op_div && (i_data_b == '0);
        acc      <= '0;
        count    <= NB_COUNT'(NB_DATA - 1);
      end else if ((state == ST_RUN) && !i_flush) begin
        acc     <= acc_step;
        shifter <= is_div ? {shifter[NB_DATA-2:0], 1'b0} : {1'b0, shifter[NB_DATA-1:1]};
        if (count != '0) begin
          count <= count - 1'b1;
        end
      end

      if (write_en) begin
        hi <= res_hi;
        lo <= res_lo;
      end
    end
  end

  assign o_done     = done;
  assign o_div_zero = div_zero_pulse;
  assign o_hi       = hi;
  assign o_lo       = lo;

endmodule

// File: tb/tb_muldiv_unit.sv
// Directed self-checking bench for muldiv_unit (NB_DATA = 32).
// Inputs are driven and outputs sampled 2 time units after each rising edge.
// The accepting edge counts as edge 1; HI/LO and o_done appear after edge 34.
module tb_muldiv_unit;

  localparam int NB_DATA      = 32;
  localparam int NB_OPERATION = 3;

  logic                    i_clock;
  logic                    i_reset;
  logic                    i_valid;
  logic [NB_OPERATION-1:0] i_op;
  logic [NB_DATA-1:0]      i_data_a;
  logic [NB_DATA-1:0]      i_data_b;
  logic                    i_flush;
  logic                    o_ready;
  logic                    o_busy;
  logic                    o_done;
  logic                    o_div_zero;
  logic [NB_DATA-1:0]      o_hi;
  logic [NB_DATA-1:0]      o_lo;

  int n_checks = 0;
  int n_fail   = 0;

  muldiv_unit #(
    .NB_DATA      (NB_DATA),
    .NB_OPERATION (NB_OPERATION)
  ) dut (
    .i_clock    (i_clock),
    .i_reset    (i_reset),
    .i_valid    (i_valid),
    .i_op       (i_op),
    .i_data_a   (i_data_a),
    .i_data_b   (i_data_b),
    .i_flush    (i_flush),
    .o_ready    (o_ready),
    .o_busy     (o_busy),
    .o_done     (o_done),
    .o_div_zero (o_div_zero),
    .o_hi       (o_hi),
    .o_lo       (o_lo)
  );

  initial i_clock = 1'b0;
  always #5 i_clock = ~i_clock;

  task automatic check(input string tag, input logic [63:0] observed, input logic [63:0] expected);
    n_checks++;
    assert (observed === expected)
    else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, observed, expected);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge i_clock);
      #2;
    end
  endtask

  // Present a request for one edge; the unit must be idle so it is taken.
  task automatic issue(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
    i_valid  = 1'b1;
    i_op     = op;
    i_data_a = a;
    i_data_b = b;
    tick(1);
    i_valid  = 1'b0;
  endtask

  // Full MULT/DIV: checks busy after accept, no result before edge 34,
  // and the result plus pulses right after edge 34. Ends in the o_done cycle.
  task automatic run_op(input string tag, input logic [2:0] op,
                        input logic [31:0] a, input logic [31:0] b,
                        input logic [31:0] prev_hi, input logic [31:0] prev_lo,
                        input logic [31:0] exp_hi, input logic [31:0] exp_lo,
                        input logic exp_dz);
    issue(op, a, b);
    check({tag, " busy after accept"}, 64'(o_busy), 64'(1));
    check({tag, " ready after accept"}, 64'(o_ready), 64'(0));
    check({tag, " done after accept"}, 64'(o_done), 64'(0));
    tick(NB_DATA);
    check({tag, " done early"}, 64'(o_done), 64'(0));
    check({tag, " hi/lo early"}, {o_hi, o_lo}, {prev_hi, prev_lo});
    tick(1);
    check({tag, " done"}, 64'(o_done), 64'(1));
    check({tag, " div_zero"}, 64'(o_div_zero), 64'(exp_dz));
    check({tag, " ready"}, 64'(o_ready), 64'(1));
    check({tag, " hi"}, 64'(o_hi), 64'(exp_hi));
    check({tag, " lo"}, 64'(o_lo), 64'(exp_lo));
  endtask

  initial begin
    logic seen_done;

    i_reset  = 1'b0;
    i_valid  = 1'b0;
    i_op     = '0;
    i_data_a = '0;
    i_data_b = '0;
    i_flush  = 1'b0;

    // Reset state
    #1;
    check("reset ready", 64'(o_ready), 64'(1));
    check("reset busy", 64'(o_busy), 64'(0));
    check("reset done", 64'(o_done), 64'(0));
    check("reset div_zero", 64'(o_div_zero), 64'(0));
    check("reset hi/lo", {o_hi, o_lo}, 64'(0));
    tick(2);
    i_reset = 1'b1;
    tick(1);

    // MTHI: visible after one edge, stays idle, no done
    issue(3'd4, 32'hA5A5_A5A5, 32'h0);
    check("mthi hi", 64'(o_hi), 64'h0000_0000_A5A5_A5A5);
    check("mthi lo", 64'(o_lo), 64'(0));
    check("mthi done", 64'(o_done), 64'(0));
    check("mthi ready", 64'(o_ready), 64'(1));

    // Code 6 is a no-op
    issue(3'd6, 32'h1234_5678, 32'h9);
    check("noop ready", 64'(o_ready), 64'(1));
    check("noop hi/lo", {o_hi, o_lo}, 64'hA5A5_A5A5_0000_0000);

    // MULT -3 * 5 = -15, then o_done lasts exactly one cycle
    run_op("mult", 3'd0, 32'hFFFF_FFFD, 32'h0000_0005,
           32'hA5A5_A5A5, 32'h0, 32'hFFFF_FFFF, 32'hFFFF_FFF1, 1'b0);
    tick(1);
    check("mult done one cycle", 64'(o_done), 64'(0));

    // MULTU max*max, then DIVU 64/8 issued in the o_done cycle
    run_op("multu", 3'd1, 32'hFFFF_FFFF, 32'hFFFF_FFFF,
           32'hFFFF_FFFF, 32'hFFFF_FFF1, 32'hFFFF_FFFE, 32'h0000_0001, 1'b0);
    run_op("divu b2b", 3'd3, 32'd64, 32'd8,
           32'hFFFF_FFFE, 32'h0000_0001, 32'h0, 32'd8, 1'b0);
    tick(1);

    // DIV -7 / 2: quotient -3, remainder -1
    run_op("div neg", 3'd2, 32'hFFFF_FFF9, 32'h0000_0002,
           32'h0, 32'd8, 32'hFFFF_FFFF, 32'hFFFF_FFFD, 1'b0);
    tick(1);

    // DIV MIN / -1 wraps to MIN, remainder 0
    run_op("div ovf", 3'd2, 32'h8000_0000, 32'hFFFF_FFFF,
           32'hFFFF_FFFF, 32'hFFFF_FFFD, 32'h0, 32'h8000_0000, 1'b0);
    tick(1);

    // DIVU 7 / 0: HI = dividend, LO = all ones, div_zero pulses
    run_op("divu zero", 3'd3, 32'd7, 32'd0,
           32'h0, 32'h8000_0000, 32'd7, 32'hFFFF_FFFF, 1'b1);
    tick(1);
    check("div_zero one cycle", 64'(o_div_zero), 64'(0));

    // MTLO
    issue(3'd5, 32'h1234_5678, 32'h0);
    check("mtlo hi/lo", {o_hi, o_lo}, 64'h0000_0007_1234_5678);

    // Flush ten edges into a MULT
    issue(3'd0, 32'd3, 32'd5);
    tick(9);
    i_flush = 1'b1;
    tick(1);
    i_flush = 1'b0;
    check("flush run ready", 64'(o_ready), 64'(1));
    check("flush run busy", 64'(o_busy), 64'(0));
    seen_done = o_done;
    for (int i = 0; i < 40; i++) begin
      tick(1);
      seen_done = seen_done | o_done;
    end
    check("flush run no done", 64'(seen_done), 64'(0));
    check("flush run hi/lo", {o_hi, o_lo}, 64'h0000_0007_1234_5678);

    // Flush on the same edge as the FIX write: flush wins
    issue(3'd0, 32'd3, 32'd5);
    tick(NB_DATA);
    check("flush fix busy", 64'(o_busy), 64'(1));
    i_flush = 1'b1;
    tick(1);
    i_flush = 1'b0;
    check("flush fix done", 64'(o_done), 64'(0));
    check("flush fix ready", 64'(o_ready), 64'(1));
    check("flush fix hi/lo", {o_hi, o_lo}, 64'h0000_0007_1234_5678);
    tick(1);
    check("flush fix done later", 64'(o_done), 64'(0));

    // Asynchronous reset mid-RUN takes effect without a clock edge
    issue(3'd1, 32'd3, 32'd5);
    tick(5);
    i_reset = 1'b0;
    #1;
    check("async rst ready", 64'(o_ready), 64'(1));
    check("async rst busy", 64'(o_busy), 64'(0));
    check("async rst done", 64'(o_done), 64'(0));
    check("async rst hi/lo", {o_hi, o_lo}, 64'(0));
    #3;
    i_reset = 1'b1;
    tick(1);

    // Unit works normally after the reset
    run_op("multu post rst", 3'd1, 32'd3, 32'd5,
           32'h0, 32'h0, 32'h0, 32'd15, 1'b0);
    tick(1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
